// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache miss path
// and the D-cache miss/writeback path. One whole-line transaction at a time,
// round-robin on contention, response routed back only to the granted side.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | no transaction; pick a winner from the pending requests
// SERVE_I  | I-cache line read in flight, pmem_* held stable until pmem_resp
// SERVE_D  | D-cache read or writeback in flight, pmem_* held until pmem_resp
// RECOVER  | one quiet cycle so the finished requester can drop its request
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } state_e;

  // last_grant encoding: 0 = I-cache, 1 = D-cache
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic ireq;
  logic dreq;
  logic grant_i;
  logic grant_d;

  assign ireq = icache_pmem_read;
  assign dreq = dcache_pmem_read | dcache_pmem_write;

  // On contention the side that did not win last time goes first.
  assign grant_d = dreq & (~ireq | (last_grant_q == GRANT_I));
  assign grant_i = ireq & ~grant_d;

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Next-state logic: grant in IDLE, hold in SERVE, release on pmem_resp.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    read_d       = read_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          addr_d       = dcache_pmem_address;
          wdata_d      = dcache_pmem_wdata;
          // Read and write together is illegal; the writeback wins so dirty
          // data is never lost.
          write_d      = dcache_pmem_write;
          read_d       = dcache_pmem_read & ~dcache_pmem_write;
        end else if (grant_i) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          addr_d       = icache_pmem_address;
          read_d       = 1'b1;
          write_d      = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = RECOVER;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // Response routing: only the side being served sees pmem_resp and data;
  // a response coinciding with reset is dropped with the transaction.
  always_comb begin
    icache_pmem_resp  = 1'b0;
    icache_pmem_rdata = '0;
    dcache_pmem_resp  = 1'b0;
    dcache_pmem_rdata = '0;
    if (pmem_resp && !rst) begin
      if (state_q == SERVE_I) begin
        icache_pmem_resp  = 1'b1;
        icache_pmem_rdata = pmem_rdata;
      end else if (state_q == SERVE_D) begin
        dcache_pmem_resp  = 1'b1;
        dcache_pmem_rdata = pmem_rdata;
      end
    end
  end

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single-side transactions, writeback,
// illegal read+write, request changes during service, round-robin contention
// and reset in the middle of a transaction.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_pmem_read;
  logic [AW-1:0] icache_pmem_address;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read;
  logic          dcache_pmem_write;
  logic [AW-1:0] dcache_pmem_address;
  logic [LW-1:0] dcache_pmem_wdata;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_tests = 0;
  int n_fail  = 0;
  int n_illegal = 0;

  localparam logic [LW-1:0] LINE_A  = {32{8'hAA}};
  localparam logic [LW-1:0] LINE_W1 = {8{32'h1234_5678}};
  localparam logic [LW-1:0] LINE_W2 = {8{32'hCAFE_F00D}};

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  always #5 clk = ~clk;

  // Read and write together from the D-cache is illegal; count every edge it is seen.
  always @(posedge clk) begin
    if (dcache_pmem_read === 1'b1 && dcache_pmem_write === 1'b1) n_illegal++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic rd, input logic wr, input logic [AW-1:0] ad);
    chk({tag, " pmem_read"},    LW'(pmem_read),    LW'(rd));
    chk({tag, " pmem_write"},   LW'(pmem_write),   LW'(wr));
    chk({tag, " pmem_address"}, LW'(pmem_address), LW'(ad));
  endtask

  task automatic chk_resp(input string tag, input logic ir, input logic [LW-1:0] id,
                          input logic dr, input logic [LW-1:0] dd);
    chk({tag, " icache_resp"},  LW'(icache_pmem_resp), LW'(ir));
    chk({tag, " icache_rdata"}, icache_pmem_rdata,     id);
    chk({tag, " dcache_resp"},  LW'(dcache_pmem_resp), LW'(dr));
    chk({tag, " dcache_rdata"}, dcache_pmem_rdata,     dd);
  endtask

  initial begin
    logic [AW-1:0] exp_addr;
    rst                 = 1'b1;
    icache_pmem_read    = 1'b0;
    icache_pmem_address = '0;
    dcache_pmem_read    = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = '0;
    dcache_pmem_wdata   = '0;
    pmem_rdata          = '0;
    pmem_resp           = 1'b0;
    tick();
    tick();

    // Reset state, with pmem_resp asserted during reset to show it is dropped.
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_A;
    #1;
    chk_strobes("reset", 1'b0, 1'b0, 32'h0);
    chk("reset pmem_wdata", pmem_wdata, '0);
    chk_resp("reset", 1'b0, '0, 1'b0, '0);
    rst       = 1'b0;
    pmem_resp = 1'b0;

    // I-only read of 0x60, memory answers in the fifth serve cycle.
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 32'h0000_0060;
    tick();
    chk_strobes("ionly grant", 1'b1, 1'b0, 32'h60);
    chk_resp("ionly grant", 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_strobes("ionly hold", 1'b1, 1'b0, 32'h60);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_A;
    #1;
    chk_resp("ionly resp", 1'b1, LINE_A, 1'b0, '0);
    tick();
    // pmem_resp still high in RECOVER must not forward a second pulse.
    chk_resp("ionly recover", 1'b0, '0, 1'b0, '0);
    chk_strobes("ionly recover", 1'b0, 1'b0, 32'h60);
    icache_pmem_read = 1'b0;
    pmem_resp        = 1'b0;
    tick();

    // pmem_resp in IDLE is ignored.
    pmem_resp = 1'b1;
    #1;
    chk_resp("idle resp", 1'b0, '0, 1'b0, '0);
    pmem_resp = 1'b0;

    // D writeback to 0x1F00, response in the fourth serve cycle.
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 32'h0000_1F00;
    dcache_pmem_wdata   = LINE_W1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_strobes("dwb hold", 1'b0, 1'b1, 32'h1F00);
      chk("dwb wdata", pmem_wdata, LINE_W1);
      chk_resp("dwb hold", 1'b0, '0, 1'b0, '0);
      tick();
    end
    chk_strobes("dwb last", 1'b0, 1'b1, 32'h1F00);
    chk("dwb wdata last", pmem_wdata, LINE_W1);
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_W2;
    #1;
    chk_resp("dwb resp", 1'b0, '0, 1'b1, LINE_W2);
    tick();
    pmem_resp         = 1'b0;
    dcache_pmem_write = 1'b0;
    #1;
    chk_resp("dwb recover", 1'b0, '0, 1'b0, '0);
    chk_strobes("dwb recover", 1'b0, 1'b0, 32'h1F00);
    tick();

    // Illegal read+write: writeback wins.
    dcache_pmem_read    = 1'b1;
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 32'h0000_0500;
    dcache_pmem_wdata   = LINE_W2;
    tick();
    chk_strobes("illegal", 1'b0, 1'b1, 32'h500);
    chk("illegal wdata", pmem_wdata, LINE_W2);
    chk("illegal seen", LW'(n_illegal), LW'(1));
    dcache_pmem_read  = 1'b0;
    dcache_pmem_write = 1'b0;
    tick();
    chk_strobes("illegal hold", 1'b0, 1'b1, 32'h500);
    pmem_resp = 1'b1;
    #1;
    chk("illegal resp", LW'(dcache_pmem_resp), LW'(1));
    tick();
    pmem_resp = 1'b0;
    tick();

    // Address change during SERVE_I is ignored.
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 32'h0000_0040;
    tick();
    chk_strobes("achg grant", 1'b1, 1'b0, 32'h40);
    icache_pmem_address = 32'h0000_0080;
    tick();
    chk_strobes("achg hold1", 1'b1, 1'b0, 32'h40);
    tick();
    chk_strobes("achg hold2", 1'b1, 1'b0, 32'h40);
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_W1;
    #1;
    chk_resp("achg resp", 1'b1, LINE_W1, 1'b0, '0);
    tick();
    pmem_resp        = 1'b0;
    icache_pmem_read = 1'b0;
    tick();

    // Simultaneous requests after reset, held through four transactions.
    rst = 1'b1;
    tick();
    rst                 = 1'b0;
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 32'h0000_0100;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 32'h200 : 32'h100;
      tick();
      chk_strobes("rr grant", 1'b1, 1'b0, exp_addr);
      pmem_resp  = 1'b1;
      pmem_rdata = LW'(k + 1);
      #1;
      if (k % 2 == 0) chk_resp("rr resp D", 1'b0, '0, 1'b1, LW'(k + 1));
      else            chk_resp("rr resp I", 1'b1, LW'(k + 1), 1'b0, '0);
      tick();
      pmem_resp = 1'b0;
      #1;
      chk("rr quiet1 read", LW'(pmem_read), LW'(0));
      tick();
      chk("rr quiet2 read", LW'(pmem_read), LW'(0));
    end
    icache_pmem_read = 1'b0;
    dcache_pmem_read = 1'b0;

    // Reset in the second SERVE_D cycle with a coincident pmem_resp.
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 32'h0000_0300;
    tick();
    chk_strobes("rstmid serve1", 1'b1, 1'b0, 32'h300);
    tick();
    rst        = 1'b1;
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_A;
    #1;
    chk_resp("rstmid resp", 1'b0, '0, 1'b0, '0);
    tick();
    chk_strobes("rstmid after", 1'b0, 1'b0, 32'h0);
    chk("rstmid wdata", pmem_wdata, '0);
    rst              = 1'b0;
    pmem_resp        = 1'b0;
    dcache_pmem_read = 1'b0;
    // From IDLE a new request is granted on the very next edge.
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 32'h0000_0440;
    tick();
    chk_strobes("rstmid idle", 1'b1, 1'b0, 32'h440);
    icache_pmem_read = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
